// File: rtl/ring_phase_decoder.sv
// Receive-side tracker for a one-hot rotating phase vector: decodes the phase index,
// checks single-step advance, locks after a run of good steps and counts faults.
module ring_phase_decoder #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] t_i,
  input  logic             sample_en_i,
  output logic [IDX_W-1:0] index_o,
  output logic             index_valid_o,
  output logic             locked_o,
  output logic             seq_error_o,
  output logic             wrap_o,
  output logic [ERR_W-1:0] err_count_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned RunW = $clog2(LOCK_COUNT + 1);
  localparam logic [RunW:0] LockCnt = LOCK_COUNT[RunW:0];
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {StHunt, StLocking, StLocked} state_e;

  state_e           state_q;
  logic [RunW-1:0]  run_q;
  logic [IDX_W-1:0] prev_q;
  logic [IDX_W-1:0] index_q;
  logic             index_valid_q;
  logic             seq_error_q;
  logic             wrap_q;
  logic [ERR_W-1:0] err_q;

  logic [CntW-1:0]  ones_cnt;
  logic [IDX_W-1:0] decoded;
  logic [IDX_W-1:0] expected;
  logic             one_hot;
  logic             in_step;
  logic [RunW:0]    run_inc;

  // Population count and position of the (last) set bit in one pass.
  always_comb begin
    ones_cnt = '0;
    decoded  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (t_i[i]) begin
        ones_cnt = ones_cnt + 1'b1;
        decoded  = IDX_W'(i);
      end
    end
  end

  assign one_hot  = (ones_cnt == CntW'(1));
  assign expected = (prev_q == LastIdx) ? '0 : prev_q + 1'b1;
  assign in_step  = one_hot && (decoded == expected);
  assign run_inc  = {1'b0, run_q} + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StHunt;
      run_q         <= '0;
      prev_q        <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      seq_error_q   <= 1'b0;
      wrap_q        <= 1'b0;
      err_q         <= '0;
    end else begin
      index_valid_q <= 1'b0;
      seq_error_q   <= 1'b0;
      wrap_q        <= 1'b0;
      if (sample_en_i) begin
        if (one_hot) begin
          index_q       <= decoded;
          prev_q        <= decoded;
          index_valid_q <= 1'b1;
        end
        unique case (state_q)
          StHunt: begin
            if (one_hot) begin
              run_q   <= RunW'(1);
              state_q <= (LOCK_COUNT == 1) ? StLocked : StLocking;
            end
          end
          StLocking: begin
            if (!one_hot) begin
              run_q   <= '0;
              state_q <= StHunt;
            end else if (in_step) begin
              run_q <= run_inc[RunW-1:0];
              if (run_inc >= LockCnt) state_q <= StLocked;
            end else begin
              run_q <= RunW'(1);
            end
          end
          StLocked: begin
            if (in_step) begin
              wrap_q <= (prev_q == LastIdx) && (decoded == '0);
            end else begin
              seq_error_q <= 1'b1;
              if (err_q != '1) err_q <= err_q + 1'b1;
              // An out-of-step but well-formed sample restarts the lock run from itself.
              run_q   <= one_hot ? RunW'(1) : '0;
              state_q <= one_hot ? StLocking : StHunt;
            end
          end
          default: begin
            run_q   <= '0;
            state_q <= StHunt;
          end
        endcase
      end
    end
  end

  assign index_o       = index_q;
  assign index_valid_o = index_valid_q;
  assign locked_o      = (state_q == StLocked);
  assign seq_error_o   = seq_error_q;
  assign wrap_o        = wrap_q;
  assign err_count_o   = err_q;

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Directed bench for ring_phase_decoder; a second instance with a 2-bit error counter
// shares the same stimulus to exercise saturation.
module tb_ring_phase_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] t;
  logic       en;

  logic [2:0] index, index2;
  logic       index_valid, index_valid2;
  logic       locked, locked2;
  logic       seq_error, seq_error2;
  logic       wrap, wrap2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ring_phase_decoder #(.WIDTH(6), .IDX_W(3), .LOCK_COUNT(3), .ERR_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .t_i(t), .sample_en_i(en),
    .index_o(index), .index_valid_o(index_valid), .locked_o(locked),
    .seq_error_o(seq_error), .wrap_o(wrap), .err_count_o(err_count)
  );

  ring_phase_decoder #(.WIDTH(6), .IDX_W(3), .LOCK_COUNT(3), .ERR_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .t_i(t), .sample_en_i(en),
    .index_o(index2), .index_valid_o(index_valid2), .locked_o(locked2),
    .seq_error_o(seq_error2), .wrap_o(wrap2), .err_count_o(err_count2)
  );

  task automatic step(input logic [5:0] v, input logic e);
    @(negedge clk);
    t  = v;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    t     = 6'b000100;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({index, index_valid, locked, seq_error, wrap} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got idx=%0d v=%0b l=%0b se=%0b w=%0b want all 0",
               index, index_valid, locked, seq_error, wrap);
    end
    total++;
    if (err_count !== 8'd0 || err_count2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_err: got %0d/%0d want 0/0", err_count, err_count2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    logic [5:0] vec [3];
    vec[0] = 6'b000001; vec[1] = 6'b000010; vec[2] = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      step(vec[i], 1'b1);
      total++;
      if (index !== 3'(i) || index_valid !== 1'b1) begin
        bad++;
        $display("FAIL lock_idx%0d: got idx=%0d v=%0b want idx=%0d v=1", i, index,
                 index_valid, i);
      end
      total++;
      if (locked !== (i == 2)) begin
        bad++;
        $display("FAIL lock_state%0d: got %0b want %0b", i, locked, (i == 2));
      end
    end
    step(6'b001000, 1'b0);
    total++;
    if (index_valid !== 1'b0 || index !== 3'd2 || locked !== 1'b1) begin
      bad++;
      $display("FAIL lock_hold: got v=%0b idx=%0d l=%0b want v=0 idx=2 l=1",
               index_valid, index, locked);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] vec [5];
    logic [2:0] eidx [5];
    int wraps = 0;
    vec[0] = 6'b001000; vec[1] = 6'b010000; vec[2] = 6'b100000;
    vec[3] = 6'b000001; vec[4] = 6'b000010;
    eidx[0] = 3; eidx[1] = 4; eidx[2] = 5; eidx[3] = 0; eidx[4] = 1;
    for (int i = 0; i < 5; i++) begin
      step(vec[i], 1'b1);
      if (wrap === 1'b1) wraps++;
      total++;
      if (index !== eidx[i] || wrap !== (i == 3) || locked !== 1'b1 || seq_error !== 1'b0) begin
        bad++;
        $display("FAIL wrap_step%0d: got idx=%0d w=%0b l=%0b se=%0b want idx=%0d w=%0b l=1 se=0",
                 i, index, wrap, locked, seq_error, eidx[i], (i == 3));
      end
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("FAIL wrap_count: got %0d want 1", wraps);
    end
  endtask

  task automatic test_fault();
    step(6'b000100, 1'b1);
    step(6'b010000, 1'b1);
    total++;
    if (seq_error !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || index !== 3'd4 ||
        index_valid !== 1'b1) begin
      bad++;
      $display("FAIL fault_detect: got se=%0b err=%0d l=%0b idx=%0d v=%0b want 1 1 0 4 1",
               seq_error, err_count, locked, index, index_valid);
    end
    step(6'b100000, 1'b1);
    total++;
    if (seq_error !== 1'b0 || locked !== 1'b0 || index !== 3'd5) begin
      bad++;
      $display("FAIL fault_run2: got se=%0b l=%0b idx=%0d want 0 0 5", seq_error, locked, index);
    end
    step(6'b000001, 1'b1);
    total++;
    if (locked !== 1'b1 || wrap !== 1'b0 || err_count !== 8'd1) begin
      bad++;
      $display("FAIL fault_relock: got l=%0b w=%0b err=%0d want 1 0 1", locked, wrap, err_count);
    end
  endtask

  task automatic test_invalid();
    step(6'b000000, 1'b1);
    total++;
    if (seq_error !== 1'b1 || locked !== 1'b0 || index !== 3'd0 || index_valid !== 1'b0 ||
        err_count !== 8'd2) begin
      bad++;
      $display("FAIL invalid_zero: got se=%0b l=%0b idx=%0d v=%0b err=%0d want 1 0 0 0 2",
               seq_error, locked, index, index_valid, err_count);
    end
    step(6'b000011, 1'b1);
    total++;
    if (seq_error !== 1'b0 || locked !== 1'b0 || index !== 3'd0 || index_valid !== 1'b0 ||
        err_count !== 8'd2) begin
      bad++;
      $display("FAIL invalid_multi: got se=%0b l=%0b idx=%0d v=%0b err=%0d want 0 0 0 0 2",
               seq_error, locked, index, index_valid, err_count);
    end
  endtask

  task automatic test_gating();
    step(6'b000010, 1'b1);
    step(6'b000100, 1'b1);
    step(6'b001000, 1'b1);
    total++;
    if (locked !== 1'b1 || index !== 3'd3) begin
      bad++;
      $display("FAIL gate_lock: got l=%0b idx=%0d want 1 3", locked, index);
    end
    for (int i = 0; i < 10; i++) begin
      step(6'(i * 7 + 1), 1'b0);
      total++;
      if (index !== 3'd3 || index_valid !== 1'b0 || locked !== 1'b1 || seq_error !== 1'b0 ||
          wrap !== 1'b0 || err_count !== 8'd2) begin
        bad++;
        $display("FAIL gate_hold%0d: got idx=%0d v=%0b l=%0b se=%0b w=%0b err=%0d", i, index,
                 index_valid, locked, seq_error, wrap, err_count);
      end
    end
    step(6'b010000, 1'b1);
    total++;
    if (index !== 3'd4 || locked !== 1'b1 || seq_error !== 1'b0) begin
      bad++;
      $display("FAIL gate_resume: got idx=%0d l=%0b se=%0b want 4 1 0", index, locked, seq_error);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (err_count !== 8'd0 || err_count2 !== 2'd0 || locked !== 1'b0 || index !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid: got err=%0d/%0d l=%0b idx=%0d want 0/0 0 0", err_count,
               err_count2, locked, index);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    int pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step(6'b000001, 1'b1);
      if (seq_error2 === 1'b1) pulses++;
      step(6'b000010, 1'b1);
      if (seq_error2 === 1'b1) pulses++;
      step(6'b000100, 1'b1);
      if (seq_error2 === 1'b1) pulses++;
      total++;
      if (locked2 !== 1'b1) begin
        bad++;
        $display("FAIL sat_lock%0d: got %0b want 1", k, locked2);
      end
      step(6'b000100, 1'b1);
      if (seq_error2 === 1'b1) pulses++;
      total++;
      if (seq_error2 !== 1'b1 || err_count2 !== 2'((k + 1 > 3) ? 3 : k + 1) ||
          err_count !== 8'(k + 1)) begin
        bad++;
        $display("FAIL sat_fault%0d: got se=%0b err2=%0d err=%0d want 1 %0d %0d", k, seq_error2,
                 err_count2, err_count, (k + 1 > 3) ? 3 : k + 1, k + 1);
      end
    end
    total++;
    if (pulses != 5) begin
      bad++;
      $display("FAIL sat_pulses: got %0d want 5", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_fault();
    test_invalid();
    test_gating();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
